// File: rtl/saturation_pipe.sv
// rtl/saturation_pipe.sv - multi-cycle per-channel saturating narrower, LANES channels per clock
// Optional feature macro: SATURATION_PIPE_STATUS_EN (adds sat_mask clamp-status output)
`timescale 1ns/1ps

module saturation_pipe #(
    parameter int CH     = 10,
    parameter int IW     = 21,
    parameter int OW     = 8,
    parameter int LANES  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready,
    input  logic [CH*IW-1:0] in,
    input  logic             received,
    output logic [CH*OW-1:0] out,
    output logic             Rdy,
    output logic             busy
`ifdef SATURATION_PIPE_STATUS_EN
    ,
    output logic [CH-1:0]    sat_mask
`endif
);

    // Index register must hold idx + LANES without wrapping.
    localparam int IDXW = $clog2(CH + LANES + 1);
    localparam logic [IDXW-1:0] CH_I    = IDXW'(CH);
    localparam logic [IDXW-1:0] LANES_I = IDXW'(LANES);

    // Output-width clamp codes: largest positive and most negative OW-bit values.
    localparam logic [OW-1:0] O_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] O_MIN = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [CH*IW-1:0]  held;
    logic [CH*OW-1:0]  sat_val;
    logic [CH-1:0]     in_group;
    logic              last_group;
`ifdef SATURATION_PIPE_STATUS_EN
    logic [CH-1:0]     sat_hit;
`endif

    // The group starting at idx is the final one once it reaches past the last channel.
    assign last_group = (idx + LANES_I) >= CH_I;

    // Per-channel saturation of the latched copy plus group membership of each channel.
    // Walking every channel and comparing against idx keeps a ragged last group in range.
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [IW-1:0] v;
        logic          hi;
        logic          lo;

        assign v = held[IW*g +: IW];

        if (SIGNED != 0) begin : g_signed
            localparam logic [IW-1:0] POS_LIM = IW'((1 << (OW-1)) - 1);
            localparam logic [IW-1:0] NEG_LIM = ~POS_LIM;
            assign hi = $signed(v) > $signed(POS_LIM);
            assign lo = $signed(v) < $signed(NEG_LIM);
        end else begin : g_unsigned
            localparam logic [IW-1:0] POS_LIM = IW'((1 << (OW-1)) - 1);
            assign hi = v > POS_LIM;
            assign lo = 1'b0;
        end

        assign sat_val[OW*g +: OW] = hi ? O_MAX : (lo ? O_MIN : v[OW-1:0]);
        assign in_group[g]         = (idx <= IDXW'(g)) && (IDXW'(g) < (idx + LANES_I));
`ifdef SATURATION_PIPE_STATUS_EN
        assign sat_hit[g]          = hi | lo;
`endif
    end

    // Control FSM: latch on accept, write one group per RUN cycle, hold result until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            held  <= '0;
            out   <= '0;
            Rdy   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready) begin
                        held  <= in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < CH; i++) begin
                        if (in_group[i]) begin
                            out[OW*i +: OW] <= sat_val[OW*i +: OW];
                        end
                    end
                    if (last_group) begin
                        Rdy   <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + LANES_I;
                    end
                end
                DONE: begin
                    // received takes priority; ready is not looked at here.
                    if (received) begin
                        Rdy   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SATURATION_PIPE_STATUS_EN
    // Clamp status: cleared on accept, each bit refreshed alongside its channel's output write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_mask <= '0;
        end else if (state == IDLE && ready) begin
            sat_mask <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < CH; i++) begin
                if (in_group[i]) begin
                    sat_mask[i] <= sat_hit[i];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_saturation_pipe.sv
// tb/tb_saturation_pipe.sv - table-driven self-checking bench for saturation_pipe
`timescale 1ns/1ps

module tb_saturation_pipe;

    localparam int CH = 10;
    localparam int IW = 21;
    localparam int OW = 8;
    localparam int C5 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             ready;
    logic             received;
    logic [CH*IW-1:0] in_v;
    logic [CH*OW-1:0] out_u, out_s;
    logic [C5*OW-1:0] out_c;
    logic             rdy_u, rdy_s, rdy_c;
    logic             busy_u, busy_s, busy_c;
`ifdef SATURATION_PIPE_STATUS_EN
    logic [CH-1:0]    mask_u, mask_s;
    logic [C5-1:0]    mask_c;
`endif

    saturation_pipe u_uns (
        .clk(clk), .rst_n(rst_n), .ready(ready), .in(in_v), .received(received),
        .out(out_u), .Rdy(rdy_u), .busy(busy_u)
`ifdef SATURATION_PIPE_STATUS_EN
        , .sat_mask(mask_u)
`endif
    );

    saturation_pipe #(.SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .ready(ready), .in(in_v), .received(received),
        .out(out_s), .Rdy(rdy_s), .busy(busy_s)
`ifdef SATURATION_PIPE_STATUS_EN
        , .sat_mask(mask_s)
`endif
    );

    saturation_pipe #(.CH(C5), .LANES(2)) u_ch5 (
        .clk(clk), .rst_n(rst_n), .ready(ready), .in(in_v[C5*IW-1:0]), .received(received),
        .out(out_c), .Rdy(rdy_c), .busy(busy_c)
`ifdef SATURATION_PIPE_STATUS_EN
        , .sat_mask(mask_c)
`endif
    );

    typedef struct {
        logic [CH*IW-1:0] din;
        logic [CH*OW-1:0] eu;
        logic [CH*OW-1:0] es;
        logic [CH-1:0]    mu;
        logic [CH-1:0]    ms;
    } vec_t;

    vec_t             tv[4];
    int               checks = 0;
    int               errors = 0;
    logic [CH*OW-1:0] prev_u, prev_s;

    function automatic logic [CH*IW-1:0] pk_in(input int v[CH]);
        logic [CH*IW-1:0] r;
        for (int i = 0; i < CH; i++) r[IW*i +: IW] = IW'(v[i]);
        return r;
    endfunction

    function automatic logic [CH*OW-1:0] pk_out(input int v[CH]);
        logic [CH*OW-1:0] r;
        for (int i = 0; i < CH; i++) r[OW*i +: OW] = OW'(v[i]);
        return r;
    endfunction

    function automatic logic [CH*OW-1:0] mix(input logic [CH*OW-1:0] nw, input logic [CH*OW-1:0] od, input int n);
        logic [CH*OW-1:0] r;
        for (int i = 0; i < CH; i++) r[OW*i +: OW] = (i < n) ? nw[OW*i +: OW] : od[OW*i +: OW];
        return r;
    endfunction

    function automatic logic [CH*IW-1:0] rnd_in();
        logic [CH*IW-1:0] r;
        for (int i = 0; i < CH; i++) r[IW*i +: IW] = IW'($urandom());
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " rdy_u"}, 256'(rdy_u), 256'(0));
        chk({name, " busy_u"}, 256'(busy_u), 256'(0));
        chk({name, " rdy_s"}, 256'(rdy_s), 256'(0));
        chk({name, " busy_s"}, 256'(busy_s), 256'(0));
        chk({name, " rdy_c"}, 256'(rdy_c), 256'(0));
        chk({name, " busy_c"}, 256'(busy_c), 256'(0));
    endtask

    // Present vector t with a one-cycle ready pulse; returns at the negedge after acceptance.
    task automatic accept_op(input int t);
        @(negedge clk);
        in_v  = tv[t].din;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        in_v  = rnd_in();
    endtask

    // finish: 0 plain acknowledge, 1 hold in DONE for 20 cycles first,
    //         2 ready+received together then accept vector nxt on the following edge.
    task automatic body_op(input int t, input int finish, input int nxt);
        logic [CH*OW-1:0] eu_k, es_k, ec_full;
        logic [C5*OW-1:0] ec_k;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            eu_k    = mix(tv[t].eu, prev_u, 2*k);
            es_k    = mix(tv[t].es, prev_s, 2*k);
            ec_full = mix(tv[t].eu, prev_u, (2*k < C5) ? 2*k : C5);
            ec_k    = ec_full[C5*OW-1:0];
            chk($sformatf("v%0d k%0d out_u", t, k), 256'(out_u), 256'(eu_k));
            chk($sformatf("v%0d k%0d out_s", t, k), 256'(out_s), 256'(es_k));
            chk($sformatf("v%0d k%0d out_c", t, k), 256'(out_c), 256'(ec_k));
            chk($sformatf("v%0d k%0d rdy_u", t, k), 256'(rdy_u), 256'(k == 5));
            chk($sformatf("v%0d k%0d rdy_c", t, k), 256'(rdy_c), 256'(k >= 3));
            chk($sformatf("v%0d k%0d busy_u", t, k), 256'(busy_u), 256'(1));
`ifdef SATURATION_PIPE_STATUS_EN
            if (k == 0) chk($sformatf("v%0d mask clr", t), 256'(mask_u), 256'(0));
`endif
        end
`ifdef SATURATION_PIPE_STATUS_EN
        chk($sformatf("v%0d mask_u", t), 256'(mask_u), 256'(tv[t].mu));
        chk($sformatf("v%0d mask_s", t), 256'(mask_s), 256'(tv[t].ms));
        chk($sformatf("v%0d mask_c", t), 256'(mask_c), 256'(tv[t].mu[C5-1:0]));
`endif
        if (finish == 1) begin
            for (int j = 0; j < 20; j++) begin
                ready = j[0];
                in_v  = rnd_in();
                @(negedge clk);
                chk($sformatf("hold%0d out_u", j), 256'(out_u), 256'(tv[t].eu));
                chk($sformatf("hold%0d out_s", j), 256'(out_s), 256'(tv[t].es));
                chk($sformatf("hold%0d rdy_u", j), 256'(rdy_u), 256'(1));
            end
        end
        prev_u = tv[t].eu;
        prev_s = tv[t].es;
        if (finish == 2) begin
            in_v     = tv[nxt].din;
            ready    = 1'b1;
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
            chk_idle("both-high");
            chk("both-high out_u", 256'(out_u), 256'(tv[t].eu));
            @(negedge clk);
            ready = 1'b0;
            in_v  = rnd_in();
            chk("re-accept busy_u", 256'(busy_u), 256'(1));
            chk("re-accept rdy_u", 256'(rdy_u), 256'(0));
        end else begin
            ready    = 1'b0;
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
            chk_idle($sformatf("v%0d ack", t));
            chk($sformatf("v%0d ack out_u", t), 256'(out_u), 256'(tv[t].eu));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ready    = 1'b0;
        received = 1'b0;
        in_v     = '0;
        prev_u   = '0;
        prev_s   = '0;

        tv[0].din = pk_in('{0, 5, 127, 128, 200, 1048576, 1, 126, 255, 64});
        tv[0].eu  = pk_out('{0, 5, 127, 127, 127, 127, 1, 126, 127, 64});
        tv[0].es  = pk_out('{0, 5, 127, 127, 127, 'h80, 1, 126, 127, 64});
        tv[0].mu  = 10'b0100111000;
        tv[0].ms  = 10'b0100111000;

        tv[1].din = pk_in('{-1, -128, -129, 127, 128, -1048576, 0, 0, 0, 0});
        tv[1].eu  = pk_out('{127, 127, 127, 127, 127, 127, 0, 0, 0, 0});
        tv[1].es  = pk_out('{'hFF, 'h80, 'h80, 'h7F, 'h7F, 'h80, 0, 0, 0, 0});
        tv[1].mu  = 10'b0000110111;
        tv[1].ms  = 10'b0000110100;

        tv[2].din = pk_in('{126, 127, 128, 129, 2097151, 1048575, 1048576, -127, 383, 256});
        tv[2].eu  = pk_out('{126, 127, 127, 127, 127, 127, 127, 127, 127, 127});
        tv[2].es  = pk_out('{126, 127, 127, 127, 'hFF, 127, 'h80, 'h81, 127, 127});
        tv[2].mu  = 10'b1111111100;
        tv[2].ms  = 10'b1101101100;

        tv[3].din = pk_in('{1, 2, 3, 4, 5, 6, 7, 8, 9, -128});
        tv[3].eu  = pk_out('{1, 2, 3, 4, 5, 6, 7, 8, 9, 127});
        tv[3].es  = pk_out('{1, 2, 3, 4, 5, 6, 7, 8, 9, 'h80});
        tv[3].mu  = 10'b1000000000;
        tv[3].ms  = 10'b0000000000;

        @(negedge clk);
        chk_idle("reset");
        chk("reset out_u", 256'(out_u), 256'(0));
        chk("reset out_s", 256'(out_s), 256'(0));
        chk("reset out_c", 256'(out_c), 256'(0));
        rst_n = 1'b1;

        for (int t = 0; t < 2; t++) begin
            accept_op(t);
            body_op(t, (t == 0) ? 1 : 0, 0);
        end
        accept_op(2);
        body_op(2, 2, 3);
        body_op(3, 0, 0);

        // Asynchronous reset two cycles into RUN, then a clean restart.
        accept_op(0);
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset busy_u", 256'(busy_u), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_idle("async reset");
        chk("async reset out_u", 256'(out_u), 256'(0));
        chk("async reset out_s", 256'(out_s), 256'(0));
        chk("async reset out_c", 256'(out_c), 256'(0));
`ifdef SATURATION_PIPE_STATUS_EN
        chk("async reset mask_u", 256'(mask_u), 256'(0));
`endif
        @(negedge clk);
        rst_n  = 1'b1;
        prev_u = '0;
        prev_s = '0;
        accept_op(1);
        body_op(1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
